forward_hazard_ctrl: RTL and testbench

FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

---
 rtl/forward_hazard_ctrl_pkg.sv | 11 +
 rtl/forward_hazard_ctrl_fwd_sel.sv | 37 +++
 rtl/forward_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_forward_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared pipeline constants: EX operand mux select encodings used by the
// hazard controller and by the CPU top that owns the operand muxes.
package forward_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/forward_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: compares one EX source register against the
// MEM and WB destinations, with the younger (MEM) result winning.
module fwd_sel
    import forward_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_src,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_valid,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    output fwd_sel_t         sel
);

    logic mem_hit;
    logic wb_hit;

    // r0 is hard-wired zero, so a write to it is never a forwarding source.
    assign mem_hit = mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_src);
    assign wb_hit  = wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == ex_src);

    always_comb begin
        sel = FWD_RF;
        if (ex_valid) begin
            if (mem_hit) begin
                sel = FWD_MEM;
            end else if (wb_hit) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding and load-use hazard control: tracks the instructions in EX, MEM
// and WB, selects EX operand sources, and stalls IF/ID on a load-use pair.
module forward_hazard_ctrl
    import forward_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    entry_t           ex_q;
    entry_t           mem_q;
    entry_t           wb_q;
    entry_t           ex_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             ex_load_pending;
    fwd_sel_t         sel_a;
    fwd_sel_t         sel_b;
    logic             unused_fields;

    assign ex_load_pending = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.rd != '0);

    assign stall_o = id_valid_i && ex_load_pending &&
                     ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));

    assign pc_write_o   = ~stall_o;
    assign ifid_write_o = ~stall_o;

    // A flush discards the ID instruction even while a stall is reported.
    always_comb begin
        ex_d = '0;
        if (id_valid_i && !stall_o && !flush_i) begin
            ex_d.valid    = 1'b1;
            ex_d.rs       = id_rs_i;
            ex_d.rt       = id_rt_i;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .ex_valid     (ex_q.valid),
        .ex_src       (ex_q.rs),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .wb_valid     (wb_q.valid),
        .wb_regwrite  (wb_q.regwrite),
        .wb_rd        (wb_q.rd),
        .sel          (sel_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .ex_valid     (ex_q.valid),
        .ex_src       (ex_q.rt),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .wb_valid     (wb_q.valid),
        .wb_regwrite  (wb_q.regwrite),
        .wb_rd        (wb_q.rd),
        .sel          (sel_b)
    );

    assign fwd_a_o = sel_a;
    assign fwd_b_o = sel_b;

    // Source fields of older entries are tracked for visibility but not consumed.
    assign unused_fields = ^{mem_q.rs, mem_q.rt, mem_q.memread,
                             wb_q.rs, wb_q.rt, wb_q.memread};

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Bench for forward_hazard_ctrl: directed instruction sequences, an
// instruction-history model checked every cycle, plus literal spot checks.
module tb_forward_hazard_ctrl;
    import forward_hazard_ctrl_pkg::*;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam int SM_W  = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             id_valid_i;
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic [REG_W-1:0] id_rd_i;
    logic             id_regwrite_i;
    logic             id_memread_i;
    logic             flush_i;
    logic [1:0]       fwd_a_o, fwd_b_o;
    logic             stall_o, pc_write_o, ifid_write_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [1:0]       sm_fwd_a, sm_fwd_b;
    logic             sm_stall, sm_pc_write, sm_ifid_write;
    logic [SM_W-1:0]  sm_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    forward_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .stall_o(stall_o), .pc_write_o(pc_write_o),
        .ifid_write_o(ifid_write_o), .stall_cnt_o(stall_cnt_o)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    forward_hazard_ctrl #(.REG_W(REG_W), .CNT_W(SM_W)) dut_sm (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .flush_i(flush_i), .fwd_a_o(sm_fwd_a), .fwd_b_o(sm_fwd_b),
        .stall_o(sm_stall), .pc_write_o(sm_pc_write),
        .ifid_write_o(sm_ifid_write), .stall_cnt_o(sm_cnt)
    );

    // Model: hist[0] is the instruction now executing, hist[1] one older, hist[2] two older.
    typedef struct {
        bit valid;
        int rs, rt, rd;
        bit writes, loads;
    } ins_t;

    ins_t hist [3];
    int   m_stalls = 0;

    function automatic int find_producer(int src);
        if (!hist[0].valid || src == 0) return 0;
        for (int age = 1; age <= 2; age++)
            if (hist[age].valid && hist[age].writes && hist[age].rd == src)
                return (age == 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit load_use();
        int rs, rt;
        rs = int'(id_rs_i);
        rt = int'(id_rt_i);
        return id_valid_i && hist[0].valid && hist[0].loads && hist[0].writes &&
               hist[0].rd != 0 && (hist[0].rd == rs || hist[0].rd == rt);
    endfunction

    function automatic int sat(int n, int w);
        int lim;
        lim = (1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 3; i++) hist[i] <= '{default: 0};
            m_stalls <= 0;
        end else begin
            if (load_use()) m_stalls <= m_stalls + 1;
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            if (id_valid_i && !load_use() && !flush_i)
                hist[0] <= '{1'b1, int'(id_rs_i), int'(id_rt_i), int'(id_rd_i),
                             id_regwrite_i, id_memread_i};
            else
                hist[0] <= '{default: 0};
        end
    end

    task automatic chk(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        chk("m_fwd_a", int'(fwd_a_o), find_producer(hist[0].rs));
        chk("m_fwd_b", int'(fwd_b_o), find_producer(hist[0].rt));
        chk("m_stall", int'(stall_o), int'(load_use()));
        chk("m_pc_write", int'(pc_write_o), int'(!load_use()));
        chk("m_ifid_write", int'(ifid_write_o), int'(!load_use()));
        chk("m_cnt", int'(stall_cnt_o), sat(m_stalls, CNT_W));
        chk("m_sm_fwd_a", int'(sm_fwd_a), find_producer(hist[0].rs));
        chk("m_sm_fwd_b", int'(sm_fwd_b), find_producer(hist[0].rt));
        chk("m_sm_stall", int'(sm_stall), int'(load_use()));
        chk("m_sm_pcw", int'(sm_pc_write & sm_ifid_write), int'(!load_use()));
        chk("m_sm_cnt", int'(sm_cnt), sat(m_stalls, SM_W));
    end

    task automatic drive(bit v, int rs, int rt, int rd, bit rw, bit mr, bit fl);
        id_valid_i    = v;
        id_rs_i       = REG_W'(rs);
        id_rt_i       = REG_W'(rt);
        id_rd_i       = REG_W'(rd);
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(bit v, int rs, int rt, int rd, bit rw, bit mr);
        drive(v, rs, rt, rd, rw, mr, 1'b0);
        tick();
    endtask

    initial begin
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_fwd_a", int'(fwd_a_o), 0);
        chk("rst_fwd_b", int'(fwd_b_o), 0);
        chk("rst_stall", int'(stall_o), 0);
        chk("rst_pc_write", int'(pc_write_o), 1);
        chk("rst_ifid_write", int'(ifid_write_o), 1);
        chk("rst_cnt", int'(stall_cnt_o), 0);
        rst_i = 1'b1;
        tick();

        // add r3,r1,r2 ; add r4,r3,r5
        issue(1, 1, 2, 3, 1, 0);
        issue(1, 3, 5, 4, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ex_mem_fwd_a", int'(fwd_a_o), 2);
        chk("ex_mem_fwd_b", int'(fwd_b_o), 0);

        // add r3 ; nop ; sub r6,r1,r3
        issue(1, 1, 2, 3, 1, 0);
        issue(0, 0, 0, 0, 0, 0);
        issue(1, 1, 3, 6, 1, 0);
        chk("wb_fwd_b", int'(fwd_b_o), 1);
        chk("wb_fwd_a", int'(fwd_a_o), 0);

        // add r3 ; add r3 ; sub r6,r1,r3 -> younger producer wins
        issue(1, 1, 2, 3, 1, 0);
        issue(1, 4, 4, 3, 1, 0);
        issue(1, 1, 3, 6, 1, 0);
        chk("prio_fwd_b", int'(fwd_b_o), 2);

        // lw r2 ; add r7,r2,r2
        issue(1, 1, 0, 2, 1, 1);
        drive(1, 2, 2, 7, 1, 0, 0);
        #1;
        chk("lu_stall", int'(stall_o), 1);
        chk("lu_pc_write", int'(pc_write_o), 0);
        chk("lu_cnt0", int'(stall_cnt_o), 0);
        tick();
        chk("lu_cnt1", int'(stall_cnt_o), 1);
        chk("lu_stall_once", int'(stall_o), 0);
        tick();
        chk("lu_fwd_a", int'(fwd_a_o), 1);
        chk("lu_fwd_b", int'(fwd_b_o), 1);

        // r0 never forwarded, never stalls
        issue(1, 1, 2, 0, 1, 0);
        issue(1, 0, 0, 5, 1, 0);
        chk("r0_fwd_a", int'(fwd_a_o), 0);
        chk("r0_fwd_b", int'(fwd_b_o), 0);
        issue(1, 1, 0, 0, 1, 1);
        drive(1, 0, 0, 5, 1, 0, 0);
        #1;
        chk("r0_stall", int'(stall_o), 0);
        tick();

        // flush with a load-use pair in ID
        issue(1, 1, 0, 2, 1, 1);
        drive(1, 2, 2, 7, 1, 0, 1);
        #1;
        chk("fl_stall", int'(stall_o), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fl_fwd_a", int'(fwd_a_o), 0);
        chk("fl_fwd_b", int'(fwd_b_o), 0);
        chk("fl_cnt", int'(stall_cnt_o), 2);

        // reset asserted mid-stall
        issue(1, 1, 0, 2, 1, 1);
        drive(1, 2, 2, 7, 1, 0, 0);
        #1;
        chk("mid_stall", int'(stall_o), 1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_stall", int'(stall_o), 0);
        chk("mid_rst_pcw", int'(pc_write_o), 1);
        chk("mid_rst_cnt", int'(stall_cnt_o), 0);
        chk("mid_rst_fwd", int'({fwd_a_o, fwd_b_o}), 0);
        tick();
        rst_i = 1'b1;
        tick();
        issue(0, 0, 0, 0, 0, 0);

        // lw r2,0(r2) repeated: a stall every other cycle
        drive(1, 2, 0, 2, 1, 1, 0);
        repeat (40) tick();
        chk("sat_cnt_wide", int'(stall_cnt_o), 20);
        chk("sat_cnt_narrow", int'(sm_cnt), 15);

        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
